// File: rtl/hex_char_scroller.sv
// Scrolling window of a run-time writable 2-bit-code message on active-low 7-segment displays.
// Optional build macro SCROLL_BLINK_EN blanks the display for one tick period after each wrap.
module hex_char_scroller #(
  parameter int N_DIGITS = 3,
  parameter int MSG_LEN  = 4,
  parameter int TICK_DIV = 50000000,
  localparam int IW      = $clog2(MSG_LEN)
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  load_en,
  input  logic [IW-1:0]         load_idx,
  input  logic [1:0]            load_char,
  output logic [7*N_DIGITS-1:0] HEX,
  output logic [IW-1:0]         offset,
  output logic                  wrap
);

  localparam int               CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]    TICK_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [IW-1:0]    OFF_MAX   = IW'(MSG_LEN - 1);
  localparam logic [IW-1:0]    OFF_ONE   = IW'(1);
  localparam logic [IW-1:0]    OFF_ZERO  = {IW{1'b0}};
  localparam logic [IW:0]      MSG_LEN_W = (IW+1)'(MSG_LEN);

  // Segment pattern (bit 0 = seg a, active-low) for a 2-bit char code.
  function automatic logic [6:0] seg_of(input logic [1:0] code);
    case (code)
      2'b00:   seg_of = 7'b1000010;
      2'b01:   seg_of = 7'b0000110;
      2'b10:   seg_of = 7'b1111001;
      2'b11:   seg_of = 7'b1111111;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  logic [CW-1:0]         count_r;
  logic [IW-1:0]         offset_r;
  logic [IW-1:0]         next_offset_s;
  logic                  wrap_r;
  logic                  tick_s;
  logic                  blank_s;
  logic [1:0]            msg_r [MSG_LEN];
  logic [7*N_DIGITS-1:0] seg_s;
  logic [7*N_DIGITS-1:0] hex_r;

  assign tick_s = run && (count_r == TICK_MAX);

  // Offset one step in the selected direction, modulo MSG_LEN.
  always_comb begin
    next_offset_s = offset_r;
    if (dir) begin
      if (offset_r == OFF_ZERO) next_offset_s = OFF_MAX;
      else                      next_offset_s = offset_r - OFF_ONE;
    end else begin
      if (offset_r == OFF_MAX)  next_offset_s = OFF_ZERO;
      else                      next_offset_s = offset_r + OFF_ONE;
    end
  end

  // Tick prescaler, scroll offset and wrap pulse.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      count_r  <= {CW{1'b0}};
      offset_r <= OFF_ZERO;
      wrap_r   <= 1'b0;
    end else begin
      if (!run)        count_r <= count_r;
      else if (tick_s) count_r <= {CW{1'b0}};
      else             count_r <= count_r + CNT_ONE;
      if (tick_s) begin
        offset_r <= next_offset_s;
        wrap_r   <= (next_offset_s == OFF_ZERO);
      end else begin
        offset_r <= offset_r;
        wrap_r   <= 1'b0;
      end
    end
  end

  // Message store; writes to slots beyond MSG_LEN-1 are dropped.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg_r[i] <= (i < 3) ? 2'(i) : 2'b11;
    end else if (load_en && ({1'b0, load_idx} < MSG_LEN_W)) begin
      msg_r[load_idx] <= load_char;
    end
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    localparam logic [IW:0] STEP = (IW+1)'((N_DIGITS - 1 - k) % MSG_LEN);
    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;

    // Message index for this digit; sum stays below 2*MSG_LEN so one subtraction suffices.
    always_comb begin
      sum_s = {1'b0, offset_r} + STEP;
      if (sum_s >= MSG_LEN_W) idx_s = IW'(sum_s - MSG_LEN_W);
      else                    idx_s = sum_s[IW-1:0];
    end

    assign seg_s[7*k +: 7] = seg_of(msg_r[idx_s]);
  end

`ifdef SCROLL_BLINK_EN
  localparam int            BW       = $clog2(TICK_DIV + 1);
  localparam logic [BW-1:0] BLK_LOAD = BW'(TICK_DIV);
  localparam logic [BW-1:0] BLK_ONE  = BW'(1);
  logic [BW-1:0] blank_cnt_r;

  // Counts down the blank window started by the step onto offset 0.
  always_ff @(posedge CLOCK_50) begin
    if (Reset)                                   blank_cnt_r <= {BW{1'b0}};
    else if (tick_s && next_offset_s == OFF_ZERO) blank_cnt_r <= BLK_LOAD;
    else if (blank_cnt_r != {BW{1'b0}})          blank_cnt_r <= blank_cnt_r - BLK_ONE;
    else                                         blank_cnt_r <= blank_cnt_r;
  end

  assign blank_s = (blank_cnt_r != {BW{1'b0}});
`else
  assign blank_s = 1'b0;
`endif

  // Registered display: one cycle behind offset/message.
  always_ff @(posedge CLOCK_50) begin
    if (Reset)        hex_r <= {(7*N_DIGITS){1'b1}};
    else if (blank_s) hex_r <= {(7*N_DIGITS){1'b1}};
    else              hex_r <= seg_s;
  end

  assign HEX    = hex_r;
  assign offset = offset_r;
  assign wrap   = wrap_r;

endmodule
